// File: rtl/ctx_pkg.sv
// ctx_pkg
//   Shared definitions for the context scheduler:
//     - sw_reason_e : reason code carried on Switch_Reason while Switch_Valid is high
//     - ctx_id_width: width of a context ID for a given context count (minimum 1)
package ctx_pkg;

    typedef enum logic [2:0] {
        SW_NONE     = 3'd0,
        SW_EXPLICIT = 3'd1,
        SW_HALT     = 3'd2,
        SW_PREEMPT  = 3'd3,
        SW_WAKE     = 3'd4
    } sw_reason_e;

    function automatic int ctx_id_width(input int num_ctx);
        return (num_ctx <= 2) ? 1 : $clog2(num_ctx);
    endfunction

endpackage

// File: rtl/rr_next_ctx.sv
// rr_next_ctx
//   Combinational wrapped first-set search. Looks at mask_i starting at
//   start_i and moving upward, wrapping past NUM_CTX-1 to 0. The context at
//   start_i is checked first and the one just below it is checked last.
//   Ports:
//     mask_i  : candidate contexts
//     start_i : first ID to consider (must be < NUM_CTX)
//     found_o : some mask bit is set
//     id_o    : selected ID (start_i when nothing is found)
module rr_next_ctx #(
    parameter int NUM_CTX = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_CTX-1:0] mask_i,
    input  logic [ID_W-1:0]    start_i,
    output logic               found_o,
    output logic [ID_W-1:0]    id_o
);

    // The loop runs from the farthest offset down to the nearest one, so the
    // last hit it records is the nearest set bit.
    always_comb begin
        int idx;
        found_o = 1'b0;
        id_o    = start_i;
        idx     = 0;
        for (int k = NUM_CTX - 1; k >= 0; k--) begin
            idx = (int'(start_i) + k) % NUM_CTX;
            if (mask_i[idx]) begin
                found_o = 1'b1;
                id_o    = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/context_scheduler.sv
// context_scheduler
//   Per-context PC save/restore plus scheduling for NUM_CTX hardware contexts.
//   All switch decisions are combinational, so NextPC can take Context_PC in
//   the same cycle. The outgoing PC is saved on that same edge.
//   Ports:
//     Slow_Clock, Raw_Reset_I : clock (rising edge) and async active-low reset
//     Cur_PC                  : next PC of the running context
//     Stall                   : freezes the slice counter and every switch decision
//     Change_Context/Target_ID: explicit switch request
//     Halt / Wake             : halt of the running context / per-context wake pulses
//     Quantum_Load/Value      : new time slice (0 disables preemption)
//     Proc_ID                 : running context (registered)
//     Context_PC              : PC of the incoming context, or of the running one when not switching
//     Switch_Valid/Reason     : switch this cycle and why (ctx_pkg codes)
//     Active_Mask, All_Halted : runnable contexts / none runnable (registered)
//     Err_Out                 : sticky illegal explicit-switch flag
module context_scheduler
    import ctx_pkg::*;
#(
    parameter int  NUM_CTX         = 4,
    parameter int  PC_WIDTH        = 13,
    parameter int  CTX_STRIDE      = 1024,
    parameter int  QUANTUM_WIDTH   = 16,
    parameter int  DEFAULT_QUANTUM = 0,
    localparam int CTX_ID_WIDTH    = ctx_id_width(NUM_CTX)
) (
    input  logic                     Slow_Clock,
    input  logic                     Raw_Reset_I,
    input  logic [PC_WIDTH-1:0]      Cur_PC,
    input  logic                     Stall,
    input  logic                     Change_Context,
    input  logic [CTX_ID_WIDTH-1:0]  Target_ID,
    input  logic                     Halt,
    input  logic [NUM_CTX-1:0]       Wake,
    input  logic                     Quantum_Load,
    input  logic [QUANTUM_WIDTH-1:0] Quantum_Value,
    output logic [CTX_ID_WIDTH-1:0]  Proc_ID,
    output logic [PC_WIDTH-1:0]      Context_PC,
    output logic                     Switch_Valid,
    output logic [2:0]               Switch_Reason,
    output logic [NUM_CTX-1:0]       Active_Mask,
    output logic                     All_Halted,
    output logic                     Err_Out
);

    logic [CTX_ID_WIDTH-1:0]  proc_id_q, proc_id_d;
    logic [PC_WIDTH-1:0]      pc_table_q [NUM_CTX];
    logic [PC_WIDTH-1:0]      pc_table_d [NUM_CTX];
    logic [NUM_CTX-1:0]       active_q, active_d;
    logic [QUANTUM_WIDTH-1:0] quantum_q, quantum_d;
    logic [QUANTUM_WIDTH-1:0] count_q, count_d;
    logic                     all_halted_q, all_halted_d;
    logic                     err_q, err_d;

    logic [NUM_CTX-1:0]      cur_bit;
    logic [CTX_ID_WIDTH-1:0] start_id;
    logic                    tgt_valid;
    logic                    tgt_active;
    logic                    expiry;
    logic [NUM_CTX-1:0]      search_mask;
    logic                    rr_found;
    logic [CTX_ID_WIDTH-1:0] rr_id;

    logic                    sw_valid;
    sw_reason_e              sw_reason;
    logic [CTX_ID_WIDTH-1:0] next_id;
    logic                    do_halt;
    logic                    set_all_halted;
    logic                    cnt_clear;
    logic                    err_set;

    // ------------------------------------------------------------------
    // Helpers derived from the current state
    // ------------------------------------------------------------------
    always_comb begin
        cur_bit    = '0;
        tgt_valid  = 1'b0;
        tgt_active = 1'b0;
        for (int i = 0; i < NUM_CTX; i++) begin
            if (proc_id_q == CTX_ID_WIDTH'(i)) begin
                cur_bit[i] = 1'b1;
            end
            if (Target_ID == CTX_ID_WIDTH'(i)) begin
                tgt_valid  = 1'b1;
                tgt_active = active_q[i];
            end
        end
        if (proc_id_q == CTX_ID_WIDTH'(NUM_CTX - 1)) begin
            start_id = '0;
        end else begin
            start_id = proc_id_q + CTX_ID_WIDTH'(1);
        end
        expiry = (quantum_q != '0) && (count_q == quantum_q - QUANTUM_WIDTH'(1));
    end

    // Search mask for the one shared round-robin picker. On a halt, wakes for
    // other contexts count immediately and the running context is excluded.
    // A preempt also excludes the running context. Leaving the all-halted
    // state keeps the running context in the mask; the wrapped search visits
    // it last.
    always_comb begin
        if (Halt) begin
            search_mask = (active_q | Wake) & ~cur_bit;
        end else if (all_halted_q && !expiry) begin
            search_mask = active_q;
        end else begin
            search_mask = active_q & ~cur_bit;
        end
    end

    rr_next_ctx #(
        .NUM_CTX (NUM_CTX),
        .ID_W    (CTX_ID_WIDTH)
    ) u_rr (
        .mask_i  (search_mask),
        .start_i (start_id),
        .found_o (rr_found),
        .id_o    (rr_id)
    );

    // ------------------------------------------------------------------
    // Switch decision: Halt > Change_Context > expiry > wake-from-all-halted
    // ------------------------------------------------------------------
    always_comb begin
        sw_valid       = 1'b0;
        sw_reason      = SW_NONE;
        next_id        = proc_id_q;
        do_halt        = 1'b0;
        set_all_halted = 1'b0;
        cnt_clear      = 1'b0;
        err_set        = 1'b0;
        if (!Stall) begin
            if (Halt) begin
                do_halt = 1'b1;
                if (rr_found) begin
                    sw_valid  = 1'b1;
                    sw_reason = SW_HALT;
                    next_id   = rr_id;
                end else begin
                    set_all_halted = 1'b1;
                end
            end else if (Change_Context) begin
                if (tgt_valid && (Target_ID == proc_id_q)) begin
                    cnt_clear = 1'b1;
                end else if (tgt_valid && tgt_active) begin
                    sw_valid  = 1'b1;
                    sw_reason = SW_EXPLICIT;
                    next_id   = Target_ID;
                end else begin
                    err_set = 1'b1;
                end
            end else if (expiry) begin
                if (rr_found) begin
                    sw_valid  = 1'b1;
                    sw_reason = SW_PREEMPT;
                    next_id   = rr_id;
                end else begin
                    cnt_clear = 1'b1;
                end
            end else if (all_halted_q && (active_q != '0)) begin
                sw_valid  = 1'b1;
                sw_reason = SW_WAKE;
                next_id   = rr_id;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    always_comb begin
        // Clearing the halting bit after the OR drops a same-cycle self-wake.
        active_d = active_q | Wake;
        if (do_halt) begin
            active_d = active_d & ~cur_bit;
        end

        pc_table_d = pc_table_q;
        if (sw_valid || do_halt) begin
            for (int i = 0; i < NUM_CTX; i++) begin
                if (cur_bit[i]) begin
                    pc_table_d[i] = Cur_PC;
                end
            end
        end

        proc_id_d = sw_valid ? next_id : proc_id_q;

        if (set_all_halted) begin
            all_halted_d = 1'b1;
        end else if (sw_valid) begin
            all_halted_d = 1'b0;
        end else begin
            all_halted_d = all_halted_q;
        end

        quantum_d = Quantum_Load ? Quantum_Value : quantum_q;

        // A new slice always restarts the count, even while stalled.
        if (Quantum_Load) begin
            count_d = '0;
        end else if (Stall) begin
            count_d = count_q;
        end else if (sw_valid || cnt_clear) begin
            count_d = '0;
        end else begin
            count_d = count_q + QUANTUM_WIDTH'(1);
        end

        err_d = err_q | err_set;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge Slow_Clock or negedge Raw_Reset_I) begin
        if (!Raw_Reset_I) begin
            proc_id_q    <= '0;
            active_q     <= '1;
            quantum_q    <= QUANTUM_WIDTH'(DEFAULT_QUANTUM);
            count_q      <= '0;
            all_halted_q <= 1'b0;
            err_q        <= 1'b0;
            for (int i = 0; i < NUM_CTX; i++) begin
                pc_table_q[i] <= PC_WIDTH'(i * CTX_STRIDE);
            end
        end else begin
            proc_id_q    <= proc_id_d;
            active_q     <= active_d;
            quantum_q    <= quantum_d;
            count_q      <= count_d;
            all_halted_q <= all_halted_d;
            err_q        <= err_d;
            pc_table_q   <= pc_table_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        Context_PC = pc_table_q[0];
        for (int i = 0; i < NUM_CTX; i++) begin
            if ((sw_valid ? next_id : proc_id_q) == CTX_ID_WIDTH'(i)) begin
                Context_PC = pc_table_q[i];
            end
        end
        Proc_ID       = proc_id_q;
        Switch_Valid  = sw_valid;
        Switch_Reason = sw_reason;
        Active_Mask   = active_q;
        All_Halted    = all_halted_q;
        Err_Out       = err_q;
    end

endmodule

// File: tb/tb_context_scheduler.sv
module tb_context_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [12:0] cur_pc;
    logic        stall;
    logic        change;
    logic [1:0]  target;
    logic        halt;
    logic [3:0]  wake;
    logic        q_load;
    logic [15:0] q_val;
    logic [1:0]  proc_id;
    logic [12:0] ctx_pc;
    logic        sw_valid;
    logic [2:0]  sw_reason;
    logic [3:0]  act_mask;
    logic        all_halted;
    logic        err;

    // three-context instance for the out-of-range target
    logic        c3_change;
    logic [1:0]  c3_target;
    logic [1:0]  c3_proc_id;
    logic [12:0] c3_ctx_pc;
    logic        c3_sw_valid;
    logic [2:0]  c3_sw_reason;
    logic [2:0]  c3_act_mask;
    logic        c3_all_halted;
    logic        c3_err;
    logic [12:0] c3_cur_pc = '0;
    logic        c3_zero   = 1'b0;
    logic [2:0]  c3_wake   = '0;
    logic [15:0] c3_qval   = '0;

    int n_chk = 0;
    int n_bad = 0;
    int exp_cpc [4] = '{1024, 500, 3072, 203};

    always #5 clk = ~clk;

    context_scheduler u_dut (
        .Slow_Clock     (clk),
        .Raw_Reset_I    (rst_n),
        .Cur_PC         (cur_pc),
        .Stall          (stall),
        .Change_Context (change),
        .Target_ID      (target),
        .Halt           (halt),
        .Wake           (wake),
        .Quantum_Load   (q_load),
        .Quantum_Value  (q_val),
        .Proc_ID        (proc_id),
        .Context_PC     (ctx_pc),
        .Switch_Valid   (sw_valid),
        .Switch_Reason  (sw_reason),
        .Active_Mask    (act_mask),
        .All_Halted     (all_halted),
        .Err_Out        (err)
    );

    context_scheduler #(.NUM_CTX(3)) u_dut3 (
        .Slow_Clock     (clk),
        .Raw_Reset_I    (rst_n),
        .Cur_PC         (c3_cur_pc),
        .Stall          (c3_zero),
        .Change_Context (c3_change),
        .Target_ID      (c3_target),
        .Halt           (c3_zero),
        .Wake           (c3_wake),
        .Quantum_Load   (c3_zero),
        .Quantum_Value  (c3_qval),
        .Proc_ID        (c3_proc_id),
        .Context_PC     (c3_ctx_pc),
        .Switch_Valid   (c3_sw_valid),
        .Switch_Reason  (c3_sw_reason),
        .Active_Mask    (c3_act_mask),
        .All_Halted     (c3_all_halted),
        .Err_Out        (c3_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        stall     = 1'b0;
        change    = 1'b0;
        target    = '0;
        halt      = 1'b0;
        wake      = '0;
        q_load    = 1'b0;
        q_val     = '0;
        c3_change = 1'b0;
        c3_target = '0;
    endtask

    initial begin
        rst_n  = 1'b0;
        cur_pc = '0;
        clr();
        #12;
        chk("rst_proc", proc_id, 0);
        chk("rst_mask", act_mask, 4'hF);
        chk("rst_allh", all_halted, 0);
        chk("rst_err", err, 0);
        chk("rst_sv", sw_valid, 0);
        chk("rst_cpc", ctx_pc, 0);
        chk("rst_err3", c3_err, 0);
        rst_n = 1'b1;
        tick();

        // explicit switch 0 -> 2, then back to prove PC_Table[0]=37
        change = 1'b1; target = 2; cur_pc = 37;
        #3;
        chk("ex_sv", sw_valid, 1);
        chk("ex_cpc", ctx_pc, 2048);
        chk("ex_rsn", sw_reason, 1);
        tick();
        chk("ex_proc", proc_id, 2);
        change = 1'b1; target = 0; cur_pc = 500;
        #3;
        chk("ex_back_cpc", ctx_pc, 37);
        tick();
        chk("ex_back_proc", proc_id, 0);
        clr();

        // quantum 3, preempt every third cycle
        q_load = 1'b1; q_val = 3;
        #3;
        chk("ql_sv", sw_valid, 0);
        tick();
        clr();
        for (int k = 1; k <= 12; k++) begin
            cur_pc = 13'(200 + k);
            #3;
            chk("pre_sv", sw_valid, (k % 3 == 0) ? 1 : 0);
            if (k % 3 == 0) begin
                chk("pre_rsn", sw_reason, 3);
                chk("pre_cpc", ctx_pc, exp_cpc[k / 3 - 1]);
            end
            tick();
            chk("pre_proc", proc_id, (k / 3) % 4);
        end
        q_load = 1'b1; q_val = 0;
        #3;
        chk("qoff_sv", sw_valid, 0);
        tick();
        clr();

        // table now: 0=203 1=206 2=209 3=212; go to 1 then halt 1,2,3,0
        change = 1'b1; target = 1; cur_pc = 110;
        #3;
        chk("h_ex_cpc", ctx_pc, 206);
        tick();
        clr();
        halt = 1'b1; cur_pc = 111;
        #3;
        chk("h1_sv", sw_valid, 1);
        chk("h1_rsn", sw_reason, 2);
        chk("h1_cpc", ctx_pc, 209);
        tick();
        chk("h1_proc", proc_id, 2);
        chk("h1_mask", act_mask, 4'b1101);
        cur_pc = 112;
        #3;
        chk("h2_cpc", ctx_pc, 212);
        tick();
        cur_pc = 113;
        #3;
        chk("h3_cpc", ctx_pc, 110);
        tick();
        chk("h3_proc", proc_id, 0);
        chk("h3_mask", act_mask, 4'b0001);
        cur_pc = 100;
        #3;
        chk("h0_sv", sw_valid, 0);
        tick();
        chk("h0_allh", all_halted, 1);
        chk("h0_mask", act_mask, 0);
        chk("h0_proc", proc_id, 0);
        clr();
        wake = 4'b0100;
        #3;
        chk("wk_sv0", sw_valid, 0);
        chk("wk_cpc0", ctx_pc, 100);
        tick();
        clr();
        #3;
        chk("wk_sv", sw_valid, 1);
        chk("wk_rsn", sw_reason, 4);
        chk("wk_cpc", ctx_pc, 112);
        tick();
        chk("wk_proc", proc_id, 2);
        chk("wk_allh", all_halted, 0);

        // illegal explicit switches
        change = 1'b1; target = 1;
        c3_change = 1'b1; c3_target = 3;
        #3;
        chk("er_sv", sw_valid, 0);
        chk("er3_sv", c3_sw_valid, 0);
        tick();
        chk("er_err", err, 1);
        chk("er3_err", c3_err, 1);
        clr();
        change = 1'b1; target = 2;
        #3;
        chk("self_sv", sw_valid, 0);
        tick();
        clr();
        tick();
        chk("er_sticky", err, 1);
        chk("er3_sticky", c3_err, 1);

        // halt + change + self-wake together
        wake = 4'b0011;
        #3;
        chk("w01_sv", sw_valid, 0);
        tick();
        chk("w01_mask", act_mask, 4'b0111);
        clr();
        halt = 1'b1; change = 1'b1; target = 1; wake = 4'b0100; cur_pc = 300;
        #3;
        chk("hc_sv", sw_valid, 1);
        chk("hc_rsn", sw_reason, 2);
        chk("hc_cpc", ctx_pc, 100);
        tick();
        chk("hc_proc", proc_id, 0);
        chk("hc_mask", act_mask, 4'b0011);
        clr();

        // stall across the quantum boundary
        q_load = 1'b1; q_val = 2;
        #3;
        tick();
        clr();
        #3;
        chk("st_sv_pre", sw_valid, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            stall = 1'b1;
            #3;
            chk("st_sv", sw_valid, 0);
            tick();
            chk("st_proc", proc_id, 0);
        end
        stall = 1'b0;
        #3;
        chk("st_rel_sv", sw_valid, 1);
        chk("st_rel_rsn", sw_reason, 3);
        chk("st_rel_cpc", ctx_pc, 111);
        tick();
        chk("st_rel_proc", proc_id, 1);

        // reset mid-slice
        #3;
        tick();
        rst_n = 1'b0;
        #1;
        chk("mr_proc", proc_id, 0);
        chk("mr_mask", act_mask, 4'hF);
        chk("mr_allh", all_halted, 0);
        chk("mr_err", err, 0);
        chk("mr_sv", sw_valid, 0);
        chk("mr_cpc", ctx_pc, 0);
        chk("mr_err3", c3_err, 0);
        #2;
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            #3;
            chk("mr_noq_sv", sw_valid, 0);
            tick();
        end
        change = 1'b1; target = 3;
        #3;
        chk("mr_tbl_cpc", ctx_pc, 3072);
        chk("mr_tbl_rsn", sw_reason, 1);
        tick();
        clr();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
